// File: rtl/calendar_pkg.sv
// Shared calendar definitions: edit-field encodings, field limits and the
// leap-year rule used by every calendar block.
package calendar_pkg;

  typedef enum logic [1:0] {
    FLD_DAY  = 2'd0,
    FLD_MON  = 2'd1,
    FLD_YEAR = 2'd2,
    FLD_NONE = 2'd3
  } field_t;

  localparam logic [3:0] MONTH_MIN = 4'd1;
  localparam logic [3:0] MONTH_MAX = 4'd12;
  localparam logic [4:0] DAY_MIN   = 5'd1;

  // Two-digit year offsets from 2000: every multiple of 4 is a leap year.
  function automatic logic is_leap(input int unsigned year);
    return (year % 4) == 0;
  endfunction

endpackage

// File: rtl/month_length.sv
// Number of days in a given month of a given year offset.
module month_length
  import calendar_pkg::*;
#(
  parameter int YEAR_W = 8
) (
  input  logic [3:0]        month,
  input  logic [YEAR_W-1:0] year,
  output logic [4:0]        mlen
);

  // Month-length lookup; invalid month codes fall back to 31.
  always_comb begin
    // NOTE: a default before the case keeps this purely combinational (no latch).
    mlen = 5'd31;
    case (month)
      4'd2:                    mlen = is_leap(32'(year)) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: mlen = 5'd30;
      default:                 mlen = 5'd31;
    endcase
  end

endmodule

// File: rtl/count_date.sv
// Day/month/year counter: advances one day per tick_day with month/year
// carry, and edits one selected field at a time with a day clamp.
module count_date
  import calendar_pkg::*;
#(
  parameter int YEAR_W    = 8,
  parameter int YEAR_MAX  = 99,
  parameter int YEAR_INIT = 16,
  parameter bit BCD_OUT   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_day,
  input  logic [1:0]        field_sel,
  input  logic              aumentar,
  input  logic              disminuir,
  output logic [YEAR_W-1:0] countdays,
  output logic [YEAR_W-1:0] countmonths,
  output logic [YEAR_W-1:0] countyears,
  output logic              carry_year
);

  localparam logic [YEAR_W-1:0] Y_MAX  = YEAR_W'(YEAR_MAX);
  localparam logic [YEAR_W-1:0] Y_INIT = YEAR_W'(YEAR_INIT);

  logic [4:0]        day,  day_n;
  logic [3:0]        mon,  mon_n,  cand_mon;
  logic [YEAR_W-1:0] year, year_n, cand_year;
  logic              carry_n;
  logic [4:0]        mlen_cur, mlen_cand;
  field_t            fsel;

  assign fsel = field_t'(field_sel);

  month_length #(.YEAR_W(YEAR_W)) u_mlen_cur (
    .month (mon),
    .year  (year),
    .mlen  (mlen_cur)
  );

  // Candidate month/year after a month or year edit, before the day clamp.
  always_comb begin
    cand_mon  = mon;
    cand_year = year;
    if (!tick_day && aumentar) begin
      case (fsel)
        FLD_MON:  cand_mon  = (mon >= MONTH_MAX || mon < MONTH_MIN) ? MONTH_MIN : mon + 4'd1;
        FLD_YEAR: cand_year = (year >= Y_MAX) ? '0 : year + 1'b1;
        default:  ;
      endcase
    end else if (!tick_day && disminuir) begin
      case (fsel)
        FLD_MON:  cand_mon  = (mon <= MONTH_MIN || mon > MONTH_MAX) ? MONTH_MAX : mon - 4'd1;
        FLD_YEAR: cand_year = (year == '0 || year > Y_MAX) ? Y_MAX : year - 1'b1;
        default:  ;
      endcase
    end
  end

  month_length #(.YEAR_W(YEAR_W)) u_mlen_cand (
    .month (cand_mon),
    .year  (cand_year),
    .mlen  (mlen_cand)
  );

  // Next date: tick has priority over edits; aumentar over disminuir.
  always_comb begin
    day_n   = day;
    mon_n   = mon;
    year_n  = year;
    carry_n = 1'b0;
    if (tick_day) begin
      if (day < mlen_cur) begin
        day_n = day + 5'd1;
      end else begin
        day_n = DAY_MIN;
        if (mon >= MONTH_MAX) begin
          mon_n   = MONTH_MIN;
          year_n  = (year >= Y_MAX) ? '0 : year + 1'b1;
          carry_n = 1'b1;
        end else begin
          mon_n = mon + 4'd1;
        end
      end
    end else if (aumentar || disminuir) begin
      case (fsel)
        FLD_DAY: begin
          if (aumentar)
            day_n = (day >= mlen_cur) ? DAY_MIN : day + 5'd1;
          else if (day == DAY_MIN)
            day_n = mlen_cur;
          else if (day == 5'd0 || day > mlen_cur)
            day_n = DAY_MIN;
          else
            day_n = day - 5'd1;
        end
        FLD_MON, FLD_YEAR: begin
          mon_n  = cand_mon;
          year_n = cand_year;
          if (day == 5'd0)
            day_n = DAY_MIN;
          else if (day > mlen_cand)
            day_n = mlen_cand;
        end
        default: ;
      endcase
    end
  end

  // Date and carry registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      day        <= DAY_MIN;
      mon        <= MONTH_MIN;
      year       <= Y_INIT;
      carry_year <= 1'b0;
    end else begin
      day        <= day_n;
      mon        <= mon_n;
      year       <= year_n;
      carry_year <= carry_n;
    end
  end

  // Two-digit packed BCD of a value below 100.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(v / 7'd10);
    units = 4'(v - 7'(tens) * 7'd10);
    return {tens, units};
  endfunction

  generate
    if (BCD_OUT) begin : g_bcd
      assign countdays   = YEAR_W'(to_bcd(7'(day)));
      assign countmonths = YEAR_W'(to_bcd(7'(mon)));
      assign countyears  = YEAR_W'(to_bcd(7'(year)));
    end else begin : g_bin
      assign countdays   = YEAR_W'(day);
      assign countmonths = YEAR_W'(mon);
      assign countyears  = year;
    end
  endgenerate

endmodule

// File: tb/tb_count_date.sv
// Self-checking bench for count_date: a calendar model compared every cycle
// against a binary-output and a BCD-output instance, plus literal date checks.
module tb_count_date;

  localparam int YMAX  = 99;
  localparam int YINIT = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_day = 1'b0;
  logic [1:0] field_sel = 2'd3;
  logic       aumentar = 1'b0;
  logic       disminuir = 1'b0;
  logic [7:0] days_b, months_b, years_b, days_d, months_d, years_d;
  logic       carry_b, carry_d;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Model date as plain integers.
  int m_day = 1, m_mon = 1, m_year = YINIT, m_carry = 0;

  always #5 clk = ~clk;

  count_date #(.YEAR_W(8), .YEAR_MAX(YMAX), .YEAR_INIT(YINIT), .BCD_OUT(1'b0)) dut_bin (
    .clk(clk), .reset(reset), .tick_day(tick_day), .field_sel(field_sel),
    .aumentar(aumentar), .disminuir(disminuir),
    .countdays(days_b), .countmonths(months_b), .countyears(years_b), .carry_year(carry_b)
  );

  count_date #(.YEAR_W(8), .YEAR_MAX(YMAX), .YEAR_INIT(YINIT), .BCD_OUT(1'b1)) dut_bcd (
    .clk(clk), .reset(reset), .tick_day(tick_day), .field_sel(field_sel),
    .aumentar(aumentar), .disminuir(disminuir),
    .countdays(days_d), .countmonths(months_d), .countyears(years_d), .carry_year(carry_d)
  );

  function automatic int days_in(int m, int y);
    int table31[13] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2 && y % 4 == 0) return 29;
    return table31[m];
  endfunction

  function automatic int bcd(int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  function automatic int min2(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Calendar model: applies the prioritised action for this edge.
  always @(posedge clk) begin
    if (reset) begin
      m_day = 1; m_mon = 1; m_year = YINIT; m_carry = 0;
    end else begin
      m_carry = 0;
      if (tick_day) begin
        m_day++;
        if (m_day > days_in(m_mon, m_year)) begin
          m_day = 1;
          m_mon++;
          if (m_mon > 12) begin
            m_mon   = 1;
            m_year  = (m_year + 1) % (YMAX + 1);
            m_carry = 1;
          end
        end
      end else if ((aumentar || disminuir) && field_sel != 2'd3) begin
        int step;
        step = aumentar ? 1 : -1;
        case (field_sel)
          2'd0: m_day  = ((m_day - 1 + step + days_in(m_mon, m_year)) % days_in(m_mon, m_year)) + 1;
          2'd1: m_mon  = ((m_mon - 1 + step + 12) % 12) + 1;
          default: m_year = (m_year + step + YMAX + 1) % (YMAX + 1);
        endcase
        m_day = min2(m_day, days_in(m_mon, m_year));
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("bin_day",   int'(days_b),   m_day);
      check("bin_month", int'(months_b), m_mon);
      check("bin_year",  int'(years_b),  m_year);
      check("bin_carry", int'(carry_b),  m_carry);
      check("bcd_day",   int'(days_d),   bcd(m_day));
      check("bcd_month", int'(months_d), bcd(m_mon));
      check("bcd_year",  int'(years_d),  bcd(m_year));
      check("bcd_carry", int'(carry_d),  m_carry);
    end
  end

  // One-cycle action; returns at the following falling edge with inputs idle.
  task automatic act(input bit rst, input bit t, input bit a, input bit d, input logic [1:0] fs);
    @(negedge clk);
    reset = rst; tick_day = t; aumentar = a; disminuir = d; field_sel = fs;
    @(negedge clk);
    reset = 1'b0; tick_day = 1'b0; aumentar = 1'b0; disminuir = 1'b0; field_sel = 2'd3;
    #1;
  endtask

  task automatic expect_date(input string name, input int d, input int m, input int y, input int c);
    check({name, "_day"},   int'(days_b),   d);
    check({name, "_month"}, int'(months_b), m);
    check({name, "_year"},  int'(years_b),  y);
    check({name, "_carry"}, int'(carry_b),  c);
  endtask

  // Reach a date from reset by editing year, then month, then day.
  task automatic set_date(input int d, input int m, input int y);
    act(1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
    for (int i = 0; i < (y - YINIT + YMAX + 1) % (YMAX + 1); i++) act(1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
    for (int i = 1; i < m; i++) act(1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
    for (int i = 1; i < d; i++) act(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    reset  = 1'b0;
    #1;
    expect_date("reset", 1, 1, 16, 0);
    check("reset_bcd_year", int'(years_d), 'h16);
    check("reset_bcd_day",  int'(days_d),  'h01);

    // Non-leap February rollover
    set_date(28, 2, 17);
    expect_date("setup_28_2_17", 28, 2, 17, 0);
    act(1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
    expect_date("tick_feb17", 1, 3, 17, 0);

    // Leap February
    set_date(28, 2, 16);
    act(1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
    expect_date("tick_feb16_a", 29, 2, 16, 0);
    act(1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
    expect_date("tick_feb16_b", 1, 3, 16, 0);

    // Year wrap with carry
    set_date(31, 12, 99);
    check("bcd_31", int'(days_d), 'h31);
    check("bcd_12", int'(months_d), 'h12);
    check("bcd_99", int'(years_d), 'h99);
    act(1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
    expect_date("wrap", 1, 1, 0, 1);
    check("wrap_bcd_carry", int'(carry_d), 1);
    act(1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
    expect_date("after_wrap", 1, 1, 0, 0);
    act(1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    expect_date("year_dec_wrap", 1, 1, 99, 0);

    // Month and year edits clamp the day
    set_date(31, 1, 16);
    act(1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
    expect_date("mon_clamp", 29, 2, 16, 0);
    act(1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
    expect_date("year_clamp", 28, 2, 17, 0);

    // Day edit wraps and the no-field select
    set_date(1, 4, 20);
    act(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    expect_date("day_dec_wrap", 30, 4, 20, 0);
    act(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    expect_date("day_inc_wrap", 1, 4, 20, 0);
    act(1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
    expect_date("field_none", 1, 4, 20, 0);
    act(1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    expect_date("mon_dec", 1, 3, 20, 0);

    // Priority: tick over edit, reset over tick
    set_date(5, 6, 20);
    act(1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
    expect_date("tick_over_edit", 6, 6, 20, 0);
    act(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    expect_date("inc_over_dec", 7, 6, 20, 0);
    act(1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
    expect_date("reset_over_tick", 1, 1, 16, 0);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_date.md
# count_date

Parametrised day/month/year counter for the clock-calendar datapath; successor to the single-field month counter. Holds a full date, advances it by one day on a `tick_day` strobe with month/year carry, and lets the user edit one selected field at a time with increment/decrement. Month length and leap years are handled internally. Outputs drive the display/RTC-write path, in binary or BCD.

## Interface
- `YEAR_W`, default 8: width of the stored year offset and of all three outputs.
- `YEAR_MAX`, default 99: largest year offset; the year range is 0..YEAR_MAX (two-digit year, century 2000).
- `YEAR_INIT`, default 16: year offset loaded at reset.
- `BCD_OUT`, default 0: 1 = outputs are two-digit packed BCD; 0 = binary.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `tick_day` in 1: single-cycle strobe; advance the date by one day.
- `field_sel` in 2: edit target. 0 = day, 1 = month, 2 = year, 3 = none.
- `aumentar` in 1: increment the selected field.
- `disminuir` in 1: decrement the selected field.
- `countdays` out YEAR_W: day, 1..31.
- `countmonths` out YEAR_W: month, 1..12.
- `countyears` out YEAR_W: year offset, 0..YEAR_MAX.
- `carry_year` out 1: one-cycle pulse when `tick_day` wraps Dec 31 → Jan 1.

## Operation
- Leap year: year offset mod 4 == 0.
- Month length `mlen(m, y)`: 31 for months 1, 3, 5, 7, 8, 10, 12. 30 for months 4, 6, 9, 11. Month 2 gives 29 in a leap year, otherwise 28.
- Priority each cycle: `reset` > `tick_day` > `aumentar` > `disminuir`. Exactly one action executes; the lower-priority inputs that cycle are dropped.
- `tick_day`:
  - day < mlen: day+1.
  - Otherwise day = 1 and month+1.
  - If month was 12: month = 1 and year+1. Year wraps YEAR_MAX → 0. `carry_year` pulses.
- Edit, day field: aumentar wraps mlen → 1. disminuir wraps 1 → mlen (current month/year).
- Edit, month field: aumentar wraps 12 → 1; disminuir wraps 1 → 12. Then day is clamped to mlen(new month, year) in the same update.
- Edit, year field: aumentar wraps YEAR_MAX → 0; disminuir wraps 0 → YEAR_MAX. Then day is clamped (Feb 29 → Feb 28 when leaving a leap year).
- `field_sel` = 3: aumentar/disminuir ignored.
- Edits never generate carries into other fields. `carry_year` fires only on `tick_day`.
- Internal state is always binary. When BCD_OUT = 1, outputs are converted combinationally: tens digit in [7:4], units in [3:0], upper bits 0. This requires YEAR_MAX ≤ 99.
- Out-of-range internal state is unreachable. If it is ever forced, the next tick or edit reloads day = 1.

## Timing
- All state is registered; each update appears on the outputs the cycle after the strobe edge. Latency is 1.
- Reset values: `countdays` = 1, `countmonths` = 1, `countyears` = YEAR_INIT (BCD-coded when BCD_OUT = 1), `carry_year` = 0.
- `reset` asserted mid-operation overrides any coincident tick or edit on that edge.
- `carry_year` is registered. It is high for exactly the one cycle in which the outputs show Jan 1 after the wrap.
- `tick_day` and the edit inputs are level-sampled each cycle. The upstream debouncer/one-shot guarantees single-cycle pulses; holding an input high repeats the action every cycle.
- No FSM beyond the three field registers. The next-state logic is purely a function of current fields and inputs.

## Structure
- Shared package `calendar_pkg`:
  - `field_sel` encodings `FLD_DAY`, `FLD_MON`, `FLD_YEAR`, `FLD_NONE`.
  - Constants `MONTH_MIN` = 1, `MONTH_MAX` = 12, `DAY_MIN` = 1.
  - Function `is_leap`.
- Sub-module `month_length`: combinational. Inputs: month (4 bits) and year offset. Output: mlen (5 bits).
  - Instantiated once for the current date.
  - Reused for the clamp via a second instance fed with the candidate month/year.
- BCD conversion is an in-block function: divide by 10 on ≤7-bit values. No sub-module.

## Test plan
- Reset, YEAR_INIT = 16 → outputs 1/1/16, `carry_year` = 0. With BCD_OUT = 1, `countyears` = 8'h16.
- Date 28/2/17, one `tick_day` → 1/3/17. Date 28/2/16 → 29/2/16, then next tick → 1/3/16.
- Date 31/12/99 (YEAR_MAX = 99), `tick_day` → 1/1/0. `carry_year` high for exactly one cycle.
- Date 31/1/16, `field_sel` = month, aumentar → 29/2/16. Then `field_sel` = year, aumentar → 28/2/17.
- `field_sel` = day on 1/4/x: disminuir → 30/4/x, then aumentar → 1/4/x. With `field_sel` = 3, aumentar → no change.
- Same cycle: `tick_day` + aumentar (month field) on 5/6/20 → 6/6/20 only. Same cycle: `reset` + `tick_day` → 1/1/YEAR_INIT.
